// File: rtl/job_register_pkg.sv
// Shared constants for the host slave register block: register offsets, field layout, bus FSM states.
package job_register_pkg;

    // Register offsets as decoded from address bits [7:4]
    localparam logic [3:0] OFS_REG0   = 4'h0;
    localparam logic [3:0] OFS_REG1   = 4'h1;
    localparam logic [3:0] OFS_REG2   = 4'h2;
    localparam logic [3:0] OFS_CTRL   = 4'h3;
    localparam logic [3:0] OFS_STATUS = 4'h4;

    // Field layout inside the 128-bit data word
    localparam int DIM_W      = 12;
    localparam int WIDTH_LSB  = 0;
    localparam int HEIGHT_LSB = 12;
    localparam int MEM_ADDR_W = 36;
    localparam int DEV_W      = 16;
    localparam int MEM_LSB    = 0;
    localparam int DEV_LSB    = 36;
    localparam int DIM_BITS   = 2 * DIM_W;
    localparam int LOC_BITS   = MEM_ADDR_W + DEV_W;

    // Bus handshake FSM
    typedef logic [1:0] bus_state_t;
    localparam bus_state_t ST_IDLE    = 2'd0;
    localparam bus_state_t ST_ACK     = 2'd1;
    localparam bus_state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/job_channel_ctrl.sv
// Per-channel job tracker: busy flag, start pulse, done clear and a busy-fell flag for the interrupt.
module job_channel_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    input  logic done,
    output logic busy,
    output logic start,
    output logic fell
);

    logic accept;

    // A done arriving with the start frees the channel in time, so the start wins.
    assign accept = start_req && (!busy || done);
    assign fell   = busy && done && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            start <= 1'b0;
        end else begin
            start <= accept;
            if (accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/job_register_slave.sv
// Host slave register responder holding the image job configuration and per-channel start/busy.
// Optional macro JOBREG_IRQ_EN enables the completion interrupt; otherwise irq is tied low.
module job_register_slave
    import job_register_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 36,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] slave_address,
    input  logic              slave_wrreq,
    output logic              slave_wrack,
    input  logic [DATA_W-1:0] slave_datain,
    input  logic              slave_rdreq,
    output logic              slave_rdack,
    output logic [DATA_W-1:0] slave_dataout,
    output logic [11:0]       image_width,
    output logic [11:0]       image_height,
    output logic [35:0]       src_address,
    output logic [15:0]       src_device,
    output logic [35:0]       dst_address,
    output logic [15:0]       dst_device,
    output logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              irq
);

    // Handshake: a request is sampled only in IDLE and must be held by the host until it sees
    // the 1-cycle ack; the FSM then waits for both requests low before accepting another.
    bus_state_t state;

    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] start_req;
    logic [NUM_CH-1:0] fell;
    logic [3:0]        sel;
    logic              mapped;
    logic              wr_go;
    logic              rd_go;
    logic              ctrl_wr;
    logic              status_rd;
    logic [DATA_W-1:0] rd_data;

    assign sel       = slave_address[7:4];
    assign mapped    = (slave_address[ADDR_W-1:8] == '0);
    assign wr_go     = (state == ST_IDLE) && slave_wrreq;
    assign rd_go     = (state == ST_IDLE) && slave_rdreq && !slave_wrreq;
    assign ctrl_wr   = wr_go && mapped && (sel == OFS_CTRL);
    assign status_rd = rd_go && mapped && (sel == OFS_STATUS);
    assign start_req = ctrl_wr ? slave_datain[NUM_CH-1:0] : '0;

    always_comb begin
        rd_data = '0;
        if (mapped) begin
            case (sel)
                OFS_REG0:   rd_data[DIM_BITS-1:0] = {image_height, image_width};
                OFS_REG1:   rd_data[LOC_BITS-1:0] = {src_device, src_address};
                OFS_REG2:   rd_data[LOC_BITS-1:0] = {dst_device, dst_address};
                OFS_STATUS: rd_data[NUM_CH-1:0]   = busy;
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            slave_wrack   <= 1'b0;
            slave_rdack   <= 1'b0;
            slave_dataout <= '0;
            image_width   <= '0;
            image_height  <= '0;
            src_address   <= '0;
            src_device    <= '0;
            dst_address   <= '0;
            dst_device    <= '0;
        end else begin
            slave_wrack <= 1'b0;
            slave_rdack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_go) begin
                        slave_wrack <= 1'b1;
                        state       <= ST_ACK;
                        if (mapped) begin
                            case (sel)
                                OFS_REG0: begin
                                    image_width  <= slave_datain[WIDTH_LSB +: DIM_W];
                                    image_height <= slave_datain[HEIGHT_LSB +: DIM_W];
                                end
                                OFS_REG1: begin
                                    src_address <= slave_datain[MEM_LSB +: MEM_ADDR_W];
                                    src_device  <= slave_datain[DEV_LSB +: DEV_W];
                                end
                                OFS_REG2: begin
                                    dst_address <= slave_datain[MEM_LSB +: MEM_ADDR_W];
                                    dst_device  <= slave_datain[DEV_LSB +: DEV_W];
                                end
                                default: ;
                            endcase
                        end
                    end else if (rd_go) begin
                        slave_rdack   <= 1'b1;
                        slave_dataout <= rd_data;
                        state         <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!slave_wrreq && !slave_rdreq) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        job_channel_ctrl u_ch (
            .clk       (clk),
            .rst       (rst),
            .start_req (start_req[i]),
            .done      (ch_done[i]),
            .busy      (busy[i]),
            .start     (ch_start[i]),
            .fell      (fell[i])
        );
    end

`ifdef JOBREG_IRQ_EN
    // A new completion in the same cycle as the clearing status read keeps irq set.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (|fell) | (irq & ~status_rd);
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{fell, status_rd};
    assign irq = 1'b0;
`endif

    logic unused_bus;
    assign unused_bus = ^{slave_address[3:0], slave_datain[DATA_W-1:LOC_BITS]};

endmodule
